// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer: packs multi-port RVFI commits into a FIFO, replays them one per handshake
// and sequences end of simulation (ECALL or cycle timeout -> drain -> halt).
package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_commit_serializer import rvfi_pkg::*; #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned TIMEOUT         = 20000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  rvfi_instr_t rvfi_i [NR_COMMIT_PORTS],
  output rvfi_instr_t rvfi_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o,
  output logic        timeout_o,
  output logic        halt_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t      state;
  rvfi_instr_t mem [DEPTH];
  logic [AW:0]   wptr, rptr, count, free, n_push;
  logic [AW-1:0] waddr [NR_COMMIT_PORTS];
  logic          wen [NR_COMMIT_PORTS];
  logic [15:0]   n_drop;
  logic [16:0]   drop_sum;
  logic [31:0]   cyc;
  logic          ecall, pop;
  // Once an ECALL is stored, later ports in the same cycle are silently discarded (not drops).
  always_comb begin
    count  = wptr - rptr;
    free   = (AW+1)'(DEPTH) - count;
    pop    = valid_o && ready_i;
    n_push = '0;
    n_drop = '0;
    ecall  = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      wen[i]   = 1'b0;
      waddr[i] = AW'(wptr + n_push);
      if (state == RUN && !ecall && (rvfi_i[i].valid || rvfi_i[i].trap)) begin
        if (n_push < free) begin
          wen[i] = 1'b1;
          n_push = n_push + (AW+1)'(1);
          ecall  = rvfi_i[i].valid && rvfi_i[i].insn == 32'h00000073;
        end else
          n_drop = n_drop + 16'd1;
      end
    end
    drop_sum = {1'b0, drop_cnt_o} + {1'b0, n_drop};
  end
  assign valid_o = count != '0;
  assign rvfi_o  = valid_o ? mem[rptr[AW-1:0]] : '0;
  assign halt_o  = state == HALTED;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++)
      if (wen[i]) mem[waddr[i]] <= rvfi_i[i];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      wptr       <= '0;
      rptr       <= '0;
      cyc        <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
      timeout_o  <= 1'b0;
    end else begin
      wptr <= wptr + n_push;
      rptr <= rptr + (AW+1)'(pop);
      if (n_drop != '0) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      // DRAIN exits on the pop that empties the FIFO so halt follows the last pop directly.
      case (state)
        RUN: begin
          cyc <= (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;
          if (cyc > TIMEOUT) begin
            state     <= DRAIN;
            timeout_o <= 1'b1;
          end else if (ecall)
            state <= DRAIN;
        end
        DRAIN:   if (count == (AW+1)'(pop)) state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb_rvfi_commit_serializer: directed self-checking bench for rvfi_commit_serializer.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;
  logic        clk = 1'b0;
  logic        rst_ni, rst_t;
  rvfi_instr_t rvfi [2];
  rvfi_instr_t rvfi_t [2];
  rvfi_instr_t rvfi_o, rvfi_o_t;
  logic        valid_o, ready, overflow_o, timeout_o, halt_o;
  logic        valid_o_t, overflow_o_t, timeout_o_t, halt_o_t;
  logic [15:0] drop_cnt_o, drop_cnt_o_t;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rvfi_commit_serializer dut (
    .clk_i(clk), .rst_ni(rst_ni), .rvfi_i(rvfi), .rvfi_o(rvfi_o), .valid_o(valid_o),
    .ready_i(ready), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .timeout_o(timeout_o), .halt_o(halt_o)
  );

  rvfi_commit_serializer #(.TIMEOUT(10)) dut_to (
    .clk_i(clk), .rst_ni(rst_t), .rvfi_i(rvfi_t), .rvfi_o(rvfi_o_t), .valid_o(valid_o_t),
    .ready_i(1'b1), .overflow_o(overflow_o_t), .drop_cnt_o(drop_cnt_o_t),
    .timeout_o(timeout_o_t), .halt_o(halt_o_t)
  );

  function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [31:0] pc,
                                     input logic [31:0] insn);
    mk = '0;
    mk.valid = v;
    mk.trap = t;
    mk.pc_rdata = pc;
    mk.pc_wdata = pc + 32'd4;
    mk.insn = insn;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rvfi[0] = '0;
    rvfi[1] = '0;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_chk++; if (rvfi_o !== '0) begin n_fail++; $display("FAIL reset_rvfi: got %h expected 0", rvfi_o); end
    n_chk++; if ({overflow_o, timeout_o, halt_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {overflow_o, timeout_o, halt_o}); end
    n_chk++; if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
    step;
    rst_ni = 1'b1;
  endtask

  task automatic test_pair;
    ready = 1'b1;
    rvfi[0] = mk(1, 0, 32'h80000000, 32'h13);
    rvfi[1] = mk(1, 0, 32'h80000004, 32'h13);
    step;
    idle;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h80000000) begin n_fail++; $display("FAIL pair_n1: got v=%b pc=%h expected v=1 pc=80000000", valid_o, rvfi_o.pc_rdata); end
    step;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h80000004) begin n_fail++; $display("FAIL pair_n2: got v=%b pc=%h expected v=1 pc=80000004", valid_o, rvfi_o.pc_rdata); end
    step;
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL pair_n3: got v=%b expected 0", valid_o); end
  endtask

  task automatic test_trap;
    rvfi[1] = mk(0, 1, 32'h100, 32'h13);
    step;
    idle;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.trap !== 1'b1 || rvfi_o.valid !== 1'b0 || rvfi_o.pc_rdata !== 32'h100) begin n_fail++; $display("FAIL trap_entry: got v=%b trap=%b valid=%b pc=%h expected 1 1 0 100", valid_o, rvfi_o.trap, rvfi_o.valid, rvfi_o.pc_rdata); end
    step;
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL trap_single: got v=%b expected 0", valid_o); end
  endtask

  task automatic test_overflow;
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rvfi[0] = mk(1, 0, 32'h200 + 32'(8 * c), 32'h13);
      rvfi[1] = mk(1, 0, 32'h204 + 32'(8 * c), 32'h13);
      step;
      n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h200) begin n_fail++; $display("FAIL ovf_stall%0d: got v=%b pc=%h expected v=1 pc=200", c, valid_o, rvfi_o.pc_rdata); end
    end
    idle;
    n_chk++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ovf_flags: got ovf=%b drop=%0d expected 1 2", overflow_o, drop_cnt_o); end
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h200 + 32'(4 * k)) begin n_fail++; $display("FAIL ovf_order%0d: got v=%b pc=%h expected v=1 pc=%h", k, valid_o, rvfi_o.pc_rdata, 32'h200 + 32'(4 * k)); end
      step;
    end
    n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got v=%b expected 0", valid_o); end
  endtask

  task automatic test_ecall;
    ready = 1'b0;
    rvfi[0] = mk(1, 0, 32'h300, 32'h13);
    rvfi[1] = mk(1, 0, 32'h304, 32'h13);
    step;
    rvfi[0] = mk(1, 0, 32'h308, 32'h13);
    rvfi[1] = '0;
    step;
    rvfi[0] = mk(1, 0, 32'h30c, 32'h00000073);
    rvfi[1] = mk(1, 0, 32'h310, 32'h13);
    step;
    idle;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h300 + 32'(4 * k) || halt_o !== 1'b0) begin n_fail++; $display("FAIL ecall_out%0d: got v=%b pc=%h halt=%b expected v=1 pc=%h halt=0", k, valid_o, rvfi_o.pc_rdata, halt_o, 32'h300 + 32'(4 * k)); end
      if (k == 3) begin
        n_chk++; if (rvfi_o.insn !== 32'h00000073) begin n_fail++; $display("FAIL ecall_insn: got %h expected 00000073", rvfi_o.insn); end
      end
      step;
    end
    n_chk++; if (halt_o !== 1'b1 || valid_o !== 1'b0 || rvfi_o !== '0) begin n_fail++; $display("FAIL ecall_halt: got halt=%b v=%b expected halt=1 v=0", halt_o, valid_o); end
    n_chk++; if (timeout_o !== 1'b0 || drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ecall_flags: got to=%b drop=%0d expected 0 2", timeout_o, drop_cnt_o); end
    rvfi[0] = mk(1, 0, 32'h600, 32'h13);
    step;
    idle;
    n_chk++; if (valid_o !== 1'b0 || halt_o !== 1'b1) begin n_fail++; $display("FAIL halted_nocap: got v=%b halt=%b expected 0 1", valid_o, halt_o); end
  endtask

  task automatic test_async_reset;
    rst_ni = 1'b0;
    step;
    rst_ni = 1'b1;
    n_chk++; if (halt_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_clear_halt: got halt=%b v=%b expected 0 0", halt_o, valid_o); end
    ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rvfi[0] = mk(1, 0, 32'h400 + 32'(8 * c), 32'h13);
      rvfi[1] = mk(1, 0, 32'h404 + 32'(8 * c), 32'h13);
      step;
    end
    rvfi[0] = mk(1, 0, 32'h420, 32'h13);
    rvfi[1] = '0;
    step;
    idle;
    n_chk++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rst_setup: got ovf=%b drop=%0d expected 1 1", overflow_o, drop_cnt_o); end
    ready = 1'b1;
    repeat (3) step;
    ready = 1'b0;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h40c) begin n_fail++; $display("FAIL rst_head: got v=%b pc=%h expected v=1 pc=40c", valid_o, rvfi_o.pc_rdata); end
    #3;
    rst_ni = 1'b0;
    #1;
    n_chk++; if (valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0 || rvfi_o !== '0) begin n_fail++; $display("FAIL rst_async: got v=%b ovf=%b drop=%0d expected 0 0 0", valid_o, overflow_o, drop_cnt_o); end
    step;
    rst_ni = 1'b1;
    rvfi[1] = mk(1, 0, 32'h500, 32'h13);
    step;
    idle;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h500 || halt_o !== 1'b0) begin n_fail++; $display("FAIL rst_resume: got v=%b pc=%h halt=%b expected v=1 pc=500 halt=0", valid_o, rvfi_o.pc_rdata, halt_o); end
    step;
    n_chk++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h500) begin n_fail++; $display("FAIL rst_hold: got v=%b pc=%h expected v=1 pc=500", valid_o, rvfi_o.pc_rdata); end
  endtask

  task automatic test_timeout;
    step;
    rst_t = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rvfi_t[0] = mk(1, 0, 32'h1000 + 32'(4 * k), 32'h13);
      step;
      n_chk++; if (valid_o_t !== (k <= 11)) begin n_fail++; $display("FAIL to_valid%0d: got %b expected %b", k, valid_o_t, k <= 11); end
      if (k <= 11) begin
        n_chk++; if (rvfi_o_t.pc_rdata !== 32'h1000 + 32'(4 * k)) begin n_fail++; $display("FAIL to_pc%0d: got %h expected %h", k, rvfi_o_t.pc_rdata, 32'h1000 + 32'(4 * k)); end
      end
      n_chk++; if (timeout_o_t !== (k >= 11) || halt_o_t !== (k >= 12)) begin n_fail++; $display("FAIL to_flags%0d: got to=%b halt=%b expected %b %b", k, timeout_o_t, halt_o_t, k >= 11, k >= 12); end
    end
    n_chk++; if (overflow_o_t !== 1'b0 || drop_cnt_o_t !== 16'd0) begin n_fail++; $display("FAIL to_noovf: got ovf=%b drop=%0d expected 0 0", overflow_o_t, drop_cnt_o_t); end
  endtask

  initial begin
    rst_ni = 1'b0;
    rst_t = 1'b0;
    ready = 1'b0;
    idle;
    rvfi_t[0] = '0;
    rvfi_t[1] = '0;
    test_reset;
    test_pair;
    test_trap;
    test_overflow;
    test_ecall;
    test_async_reset;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
